// File: rtl/pwm_ctrl_pkg.sv
// Shared types and constants for the PWM duty-cycle ramp controller.
package pwm_ctrl_pkg;

    localparam int PWM_W  = 32;
    localparam int INTV_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } ramp_state_e;

    typedef struct packed {
        logic [PWM_W-1:0]  target;
        logic [PWM_W-1:0]  step;
        logic [INTV_W-1:0] interval;
    } ramp_cmd_t;

    // An interval of 0 behaves like 1: one step per period.
    function automatic logic [INTV_W-1:0] interval_reload(input logic [INTV_W-1:0] iv);
        return (iv == '0) ? INTV_W'(1) : iv;
    endfunction

endpackage

// File: rtl/pwm_ramp_chan.sv
// One ramp channel: mirror of the pwm period counter, IDLE/RAMP FSM and
// the saturating step datapath that walks duty toward the target.
module pwm_ramp_chan
    import pwm_ctrl_pkg::*;
#(
    parameter int             W        = PWM_W,
    parameter logic [W-1:0]   DUTY_RST = '0
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              enable_i,
    input  logic [W-1:0]      period_i,
    input  logic              cmd_load_i,
    input  ramp_cmd_t         cmd_i,
    input  logic              abort_i,
    output logic [W-1:0]      duty_o,
    output logic              busy_o,
    output logic              done_o
);

    ramp_state_e       state_q, state_d;
    logic [W-1:0]      cnt_q, cnt_d;
    logic [W-1:0]      duty_q, duty_d;
    logic [W-1:0]      target_q, target_d;
    logic [W-1:0]      step_q, step_d;
    logic [INTV_W-1:0] intv_q, intv_d;
    logic [INTV_W-1:0] cdown_q, cdown_d;
    logic              done_q, done_d;

    logic              boundary;
    logic [W:0]        period_p1;
    logic [W:0]        tgt_ext;
    logic [W:0]        tgt_clamped;
    logic [W:0]        duty_ext;
    logic [W:0]        step_ext;
    logic [W:0]        sum;
    logic [W:0]        diff;
    logic [W:0]        next_duty;

    assign boundary = enable_i && (cnt_q == period_i);

    // Mirror counter: same wrap behaviour as pwm, including overrun past a lowered period.
    always_comb begin
        if (!enable_i) begin
            cnt_d = '0;
        end else if (cnt_q == period_i) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Step datapath: one extra bit so period+1 and duty+step never wrap.
    always_comb begin
        period_p1   = {1'b0, period_i} + (W+1)'(1);
        tgt_ext     = {1'b0, target_q};
        tgt_clamped = (tgt_ext > period_p1) ? period_p1 : tgt_ext;
        duty_ext    = {1'b0, duty_q};
        step_ext    = {1'b0, step_q};
        sum         = duty_ext + step_ext;
        diff        = duty_ext - tgt_clamped;
        if (step_q == '0) begin
            next_duty = tgt_clamped;
        end else if (duty_ext < tgt_clamped) begin
            next_duty = (sum > tgt_clamped) ? tgt_clamped : sum;
        end else if (duty_ext > tgt_clamped) begin
            next_duty = (diff <= step_ext) ? tgt_clamped : (duty_ext - step_ext);
        end else begin
            next_duty = tgt_clamped;
        end
    end

    // FSM next state: latch command, count down boundaries, step, finish or abort.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        duty_d   = duty_q;
        target_d = target_q;
        step_d   = step_q;
        intv_d   = intv_q;
        cdown_d  = cdown_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_load_i) begin
                    target_d = W'(cmd_i.target);
                    step_d   = W'(cmd_i.step);
                    intv_d   = cmd_i.interval;
                    cdown_d  = interval_reload(cmd_i.interval);
                    state_d  = RAMP;
                end
            end
            RAMP: begin
                if (abort_i) begin
                    // Abort beats a coincident step: duty stays as it is.
                    state_d = IDLE;
                end else if (boundary) begin
                    if (cdown_q <= INTV_W'(1)) begin
                        duty_d  = next_duty[W-1:0];
                        cdown_d = interval_reload(intv_q);
                        if (next_duty == tgt_clamped) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cdown_d = cdown_q - INTV_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            duty_q   <= DUTY_RST;
            target_q <= '0;
            step_q   <= '0;
            intv_q   <= '0;
            cdown_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            duty_q   <= duty_d;
            target_q <= target_d;
            step_q   <= step_d;
            intv_q   <= intv_d;
            cdown_q  <= cdown_d;
            done_q   <= done_d;
        end
    end

    assign duty_o = duty_q;
    assign busy_o = (state_q == RAMP);
    assign done_o = done_q;

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Top level: command decode, handshake/error logic and per-channel instances.
module pwm_ramp_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int             NCH      = 3,
    parameter int             W        = PWM_W,
    parameter logic [W-1:0]   DUTY_RST = '0
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic [NCH-1:0]          enable_i,
    input  logic [NCH-1:0][W-1:0]   pwm_period_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [1:0]              cmd_ch_i,
    input  logic [W-1:0]            cmd_target_i,
    input  logic [W-1:0]            cmd_step_i,
    input  logic [INTV_W-1:0]       cmd_interval_i,
    input  logic [NCH-1:0]          abort_i,
    output logic [NCH-1:0][W-1:0]   duty_cycle_o,
    output logic [NCH-1:0]          busy_o,
    output logic [NCH-1:0]          done_o,
    output logic                    cmd_err_o
);

    ramp_cmd_t      cmd;
    logic [NCH-1:0] load;
    logic           ch_in_range;
    logic           cmd_err_q;

    assign cmd = '{target:   PWM_W'(cmd_target_i),
                   step:     PWM_W'(cmd_step_i),
                   interval: cmd_interval_i};

    assign ch_in_range = int'(cmd_ch_i) < NCH;

    // Ready depends only on the addressed channel's busy flag, never on valid.
    always_comb begin
        cmd_ready_o = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (int'(cmd_ch_i) == i) begin
                cmd_ready_o = !busy_o[i];
            end
        end
    end

    // One-cycle error pulse for a command addressed beyond the last channel.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cmd_err_q <= 1'b0;
        end else begin
            cmd_err_q <= cmd_valid_i && !ch_in_range;
        end
    end

    assign cmd_err_o = cmd_err_q;

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        assign load[g] = cmd_valid_i && (int'(cmd_ch_i) == g) && !busy_o[g];

        pwm_ramp_chan #(
            .W        (W),
            .DUTY_RST (DUTY_RST)
        ) u_chan (
            .clk_i      (clk_i),
            .rstn_i     (rstn_i),
            .enable_i   (enable_i[g]),
            .period_i   (pwm_period_i[g]),
            .cmd_load_i (load[g]),
            .cmd_i      (cmd),
            .abort_i    (abort_i[g]),
            .duty_o     (duty_cycle_o[g]),
            .busy_o     (busy_o[g]),
            .done_o     (done_o[g])
        );
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl. Three channels, period 9 (10 cycles per
// period). Channels are enabled just after edge 4, so counter=9 boundaries sit
// after edges 13, 23, 33, ... and stepped duty shows after edges 14, 24, 34, ...
module tb_pwm_ramp_ctrl;

    localparam int NCH = 3;
    localparam int W   = 32;

    logic                  clk;
    logic                  rstn;
    logic [NCH-1:0]        enable;
    logic [NCH-1:0][W-1:0] period;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_ch;
    logic [W-1:0]          cmd_target;
    logic [W-1:0]          cmd_step;
    logic [15:0]           cmd_interval;
    logic [NCH-1:0]        abort;
    logic [NCH-1:0][W-1:0] duty;
    logic [NCH-1:0]        busy;
    logic [NCH-1:0]        done;
    logic                  cmd_err;

    int total = 0;
    int bad = 0;
    int now_edge = 0;
    int done1_cnt = 0;
    int done2_cnt = 0;
    int done1_base = 0;
    int done2_base = 0;

    pwm_ramp_ctrl #(.NCH(NCH), .W(W), .DUTY_RST('0)) dut (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .enable_i       (enable),
        .pwm_period_i   (period),
        .cmd_valid_i    (cmd_valid),
        .cmd_ready_o    (cmd_ready),
        .cmd_ch_i       (cmd_ch),
        .cmd_target_i   (cmd_target),
        .cmd_step_i     (cmd_step),
        .cmd_interval_i (cmd_interval),
        .abort_i        (abort),
        .duty_cycle_o   (duty),
        .busy_o         (busy),
        .done_o         (done),
        .cmd_err_o      (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Done pulses counted mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (done[1]) done1_cnt++;
        if (done[2]) done2_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after rising edge number e.
    task automatic goto(input int e);
        while (now_edge < e) begin
            @(posedge clk);
            now_edge++;
        end
        #1;
    endtask

    task automatic present(input logic [1:0] ch, input logic [31:0] tgt,
                           input logic [31:0] stp, input logic [15:0] iv);
        cmd_valid    = 1'b1;
        cmd_ch       = ch;
        cmd_target   = tgt;
        cmd_step     = stp;
        cmd_interval = iv;
    endtask

    task automatic idle_cmd();
        cmd_valid    = 1'b0;
        cmd_ch       = 2'd0;
        cmd_target   = '0;
        cmd_step     = '0;
        cmd_interval = '0;
    endtask

    initial begin
        rstn   = 1'b0;
        enable = '0;
        period = '0;
        abort  = '0;
        idle_cmd();

        goto(2);
        rstn = 1'b1;

        // Reset state
        goto(3);
        check("rst_duty0", duty[0], 0);
        check("rst_duty1", duty[1], 0);
        check("rst_duty2", duty[2], 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(cmd_err), 0);
        check("rst_ready", 32'(cmd_ready), 1);

        goto(4);
        enable = 3'b111;
        for (int i = 0; i < NCH; i++) period[i] = 32'd9;

        // 1: up-ramp ch0 0 -> 2 -> 4 -> 6
        goto(5);
        present(2'd0, 32'd6, 32'd2, 16'd1);
        check("t1_ready", 32'(cmd_ready), 1);
        goto(6);
        check("t1_busy", 32'(busy[0]), 1);
        // preload ch1 to duty 7 with a jump
        present(2'd1, 32'd7, 32'd0, 16'd1);
        goto(7);
        idle_cmd();
        check("pre_ch1_busy", 32'(busy[1]), 1);
        goto(13);
        check("t1_duty_at_boundary", duty[0], 0);
        goto(14);
        check("t1_duty_step1", duty[0], 2);
        check("pre_ch1_duty", duty[1], 7);
        check("pre_ch1_done", 32'(done[1]), 1);
        check("pre_ch1_idle", 32'(busy[1]), 0);

        // 2: down-ramp ch1 7 -> 4 -> 1 -> 0, interval 2
        goto(15);
        present(2'd1, 32'd0, 32'd3, 16'd2);
        goto(16);
        idle_cmd();
        done1_base = done1_cnt;
        check("t2_busy", 32'(busy[1]), 1);

        // 3: jump with clamp on ch2, then bad channel
        goto(17);
        present(2'd2, 32'd50, 32'd0, 16'd0);
        goto(18);
        present(2'd3, 32'd99, 32'd1, 16'd1);
        check("t3_badch_ready", 32'(cmd_ready), 1);
        goto(19);
        idle_cmd();
        check("t3_err_pulse", 32'(cmd_err), 1);
        check("t3_busy_unchanged", 32'(busy), 32'b111);
        check("t3_duty0_unchanged", duty[0], 2);
        check("t3_duty1_unchanged", duty[1], 7);
        check("t3_duty2_unchanged", duty[2], 0);
        goto(20);
        check("t3_err_one_cycle", 32'(cmd_err), 0);
        goto(24);
        check("t1_duty_step2", duty[0], 4);
        check("t2_duty_hold", duty[1], 7);
        check("t3_jump_clamped", duty[2], 10);
        check("t3_done", 32'(done[2]), 1);
        check("t3_idle", 32'(busy[2]), 0);

        // 4: ch2 down-ramp by 1, busy handshake, abort on a boundary
        goto(25);
        present(2'd2, 32'd0, 32'd1, 16'd1);
        goto(26);
        idle_cmd();
        done2_base = done2_cnt;
        goto(34);
        check("t1_duty_final", duty[0], 6);
        check("t1_done", 32'(done[0]), 1);
        check("t1_idle", 32'(busy[0]), 0);
        check("t2_duty_step1", duty[1], 4);
        check("t4_duty_step1", duty[2], 9);
        goto(35);
        check("t1_done_one_cycle", 32'(done[0]), 0);
        // 5: new ch0 ramp 6 -> 4 -> 2 -> 0 that gets disabled midway
        present(2'd0, 32'd0, 32'd2, 16'd1);
        goto(36);
        present(2'd2, 32'd3, 32'd0, 16'd1);
        check("t4_busy_not_ready", 32'(cmd_ready), 0);
        goto(37);
        idle_cmd();
        goto(44);
        check("t5_duty_step1", duty[0], 4);
        check("t2_duty_hold2", duty[1], 4);
        check("t4_second_cmd_ignored", duty[2], 8);
        goto(45);
        enable = 3'b110;
        goto(53);
        abort = 3'b100;
        check("t4_busy_before_abort", 32'(busy[2]), 1);
        goto(54);
        abort = '0;
        check("t4_abort_idle", 32'(busy[2]), 0);
        check("t4_abort_duty_held", duty[2], 8);
        check("t2_duty_step2", duty[1], 1);
        check("t5_frozen_duty", duty[0], 4);
        check("t5_frozen_busy", 32'(busy[0]), 1);
        goto(64);
        check("t5_frozen_duty_late", duty[0], 4);
        check("t5_frozen_busy_late", 32'(busy[0]), 1);
        check("t4_duty_still_held", duty[2], 8);
        goto(65);
        enable = 3'b111;
        check("t4_no_done", 32'(done2_cnt - done2_base), 0);
        goto(74);
        check("t5_wait_first_boundary", duty[0], 4);
        check("t2_duty_final", duty[1], 0);
        check("t2_done", 32'(done[1]), 1);
        goto(75);
        check("t5_resumed", duty[0], 2);
        check("t2_idle", 32'(busy[1]), 0);
        goto(80);
        check("t2_single_done", 32'(done1_cnt - done1_base), 1);
        goto(85);
        check("t5_duty_final", duty[0], 0);
        check("t5_done", 32'(done[0]), 1);
        check("t5_idle", 32'(busy[0]), 0);

        // 6: reset in the middle of a ch1 up-ramp
        goto(90);
        present(2'd1, 32'd9, 32'd1, 16'd1);
        goto(91);
        idle_cmd();
        goto(94);
        check("t6_duty_step1", duty[1], 1);
        goto(104);
        check("t6_duty_step2", duty[1], 2);
        goto(105);
        #2;
        rstn = 1'b0;
        #1;
        check("t6_rst_duty0", duty[0], 0);
        check("t6_rst_duty1", duty[1], 0);
        check("t6_rst_duty2", duty[2], 0);
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_ready", 32'(cmd_ready), 1);
        goto(106);
        #2;
        rstn = 1'b1;
        goto(107);
        present(2'd1, 32'd2, 32'd2, 16'd3);
        check("t6_post_ready", 32'(cmd_ready), 1);
        goto(108);
        idle_cmd();
        check("t6_post_busy", 32'(busy[1]), 1);
        goto(126);
        check("t6_post_wait", duty[1], 0);
        goto(136);
        check("t6_post_duty", duty[1], 2);
        check("t6_post_done", 32'(done[1]), 1);
        goto(137);
        check("t6_post_idle", 32'(busy[1]), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
